// File: rtl/mips_regfile_mp.sv
// mips_regfile_mp
//   Multi-port MIPS general-purpose register file for the dual-issue pipeline.
//   NR combinational read ports, two write ports (B has priority over A),
//   an optional write-to-read bypass, an optional hardwired zero register and
//   a background clear engine that zeroes one entry per cycle.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset (clears array and clear engine)
//   rd_addr   NR packed read addresses, port k at [k*L +: L]
//   rd_data   NR packed read data, port k at [k*W +: W]
//   wa_en/wa_addr/wa_data   write port A
//   wb_en/wb_addr/wb_data   write port B (wins over A on the same address)
//   clr_req   single-cycle request to start a background clear
//   clr_busy  high while the clear engine walks the array
//   clr_done  one-cycle pulse after the last entry is cleared
module mips_regfile_mp #(
    parameter int W        = 32,
    parameter int L        = 5,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NR*L-1:0] rd_addr,
    output logic [NR*W-1:0] rd_data,
    input  logic            wa_en,
    input  logic [L-1:0]    wa_addr,
    input  logic [W-1:0]    wa_data,
    input  logic            wb_en,
    input  logic [L-1:0]    wb_addr,
    input  logic [W-1:0]    wb_data,
    input  logic            clr_req,
    output logic            clr_busy,
    output logic            clr_done
);

    localparam int N = 2 ** L;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t         state;
    logic [L-1:0]   ptr;
    logic [W-1:0]   mem [N];
    logic           clr_we;

    // Address 0 is read-only when the zero register is enabled.
    function automatic logic wr_ok(input logic [L-1:0] a);
        return (ZERO_REG == 0) || (a != '0);
    endfunction

    assign clr_we = (state == CLEAR);

    // Clear engine: walks ptr from 0 to N-1, one entry per cycle.
    // A request arriving during the clr_done cycle is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req && !clr_done) begin
                        state    <= CLEAR;
                        ptr      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == L'(N - 1)) begin
                        state    <= IDLE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array update. Later assignments win: clear, then A, then B, so an
    // external write overrides the clear and B overrides A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else begin
            if (clr_we) mem[ptr] <= '0;
            if (wa_en && wr_ok(wa_addr)) mem[wa_addr] <= wa_data;
            if (wb_en && wr_ok(wb_addr)) mem[wb_addr] <= wb_data;
        end
    end

    // Read ports. The zero register check comes first so address 0 never
    // bypasses a (discarded) write.
    always_comb begin
        logic [L-1:0] a;
        logic [W-1:0] v;
        rd_data = '0;
        a       = '0;
        v       = '0;
        for (int k = 0; k < NR; k++) begin
            a = rd_addr[k*L +: L];
            if (ZERO_REG != 0 && a == '0)
                v = '0;
            else if (BYPASS != 0 && wb_en && wb_addr == a)
                v = wb_data;
            else if (BYPASS != 0 && wa_en && wa_addr == a)
                v = wa_data;
            else if (BYPASS != 0 && clr_we && ptr == a)
                v = '0;
            else
                v = mem[a];
            rd_data[k*W +: W] = v;
        end
    end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Testbench for mips_regfile_mp: a bypassing instance (default parameters)
// and a non-bypassing instance share all inputs. A reference model of the
// array and clear engine supplies expected read values, which are queued when
// an address is driven and popped when the read data is sampled.
module tb_mips_regfile_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data, rd_data_nb;
    logic        wa_en = 1'b0, wb_en = 1'b0, clr_req = 1'b0;
    logic [4:0]  wa_addr = '0, wb_addr = '0;
    logic [31:0] wa_data = '0, wb_data = '0;
    logic        clr_busy, clr_done, clr_busy_nb, clr_done_nb;

    mips_regfile_mp u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    mips_regfile_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .clr_req(clr_req), .clr_busy(clr_busy_nb), .clr_done(clr_done_nb)
    );

    always #500 clk = ~clk;

    // Reference model
    logic [31:0] m [32];
    bit          mbusy, mdone;
    int          mptr;
    int          n_vec = 0, n_err = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m[i] = '0;
        mbusy = 0;
        mdone = 0;
        mptr  = 0;
    endtask

    task automatic model_edge();
        bit nd;
        nd = 0;
        if (mbusy) m[mptr] = '0;
        if (wa_en && wa_addr != 0) m[wa_addr] = wa_data;
        if (wb_en && wb_addr != 0) m[wb_addr] = wb_data;
        if (!mbusy) begin
            if (clr_req && !mdone) begin
                mbusy = 1;
                mptr  = 0;
            end
        end else begin
            if (mptr == 31) begin
                mbusy = 0;
                nd    = 1;
            end
            mptr = (mptr + 1) % 32;
        end
        mdone = nd;
    endtask

    function automatic logic [31:0] exp_rd(input int a);
        if (a == 0) return '0;
        if (wb_en && wb_addr == 5'(a)) return wb_data;
        if (wa_en && wa_addr == 5'(a)) return wa_data;
        if (mbusy && mptr == a) return '0;
        return m[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic rd_exp(input int port, input int a, input string tag, input logic [31:0] e);
        rd_addr[port*5 +: 5] = 5'(a);
        exp_q.push_back(e);
        #1;
        chk(tag, rd_data[port*32 +: 32], exp_q.pop_front());
    endtask

    task automatic rd_check(input int port, input int a, input string tag);
        rd_exp(port, a, tag, exp_rd(a));
    endtask

    task automatic idle_wr();
        wa_en = 0;
        wb_en = 0;
    endtask

    task automatic fill();
        for (int i = 0; i < 32; i += 2) begin
            wa_en = 1; wa_addr = 5'(i);     wa_data = 32'(i + 1);
            wb_en = 1; wb_addr = 5'(i + 1); wb_data = 32'(i + 2);
            tick();
        end
        idle_wr();
    endtask

    initial begin
        #(1000 * 5000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        model_reset();

        // Reset: everything reads zero, engine idle
        tick();
        rd_exp(0, 5, "rst_rd", 32'h0);
        chk("rst_busy", 32'(clr_busy), 32'h0);
        chk("rst_done", 32'(clr_done), 32'h0);
        tick();
        rst = 0;
        for (int a = 0; a < 32; a++) begin
            rd_exp(0, a, "init_p0", 32'h0);
            rd_exp(1, a, "init_p1", 32'h0);
        end

        // Zero register: write discarded, no bypass either
        wa_en = 1; wa_addr = 0; wa_data = 32'hDEADBEEF;
        rd_exp(0, 0, "zero_byp", 32'h0);
        tick();
        idle_wr();
        rd_exp(0, 0, "zero_rd", 32'h0);

        // Collision: B wins
        wa_en = 1; wa_addr = 5; wa_data = 32'h1111;
        wb_en = 1; wb_addr = 5; wb_data = 32'h2222;
        tick();
        idle_wr();
        rd_exp(0, 5, "collide", 32'h2222);

        // Plain write then read on port 1
        wa_en = 1; wa_addr = 7; wa_data = 32'h7777;
        tick();
        idle_wr();
        rd_exp(1, 7, "wr_rd_p1", 32'h7777);

        // Bypass vs no bypass
        wa_en = 1; wa_addr = 9; wa_data = 32'hA5A5A5A5;
        rd_exp(0, 9, "byp_a", 32'hA5A5A5A5);
        chk("nobyp_a", rd_data_nb[31:0], 32'h0);
        wb_en = 1; wb_addr = 9; wb_data = 32'h5A5A5A5A;
        rd_exp(0, 9, "byp_b_over_a", 32'h5A5A5A5A);
        tick();
        idle_wr();
        rd_exp(0, 9, "byp_after", 32'h5A5A5A5A);
        chk("nobyp_after", rd_data_nb[31:0], 32'h5A5A5A5A);

        // Clear engine with mid-clear request, same-cycle write and write ahead
        fill();
        rd_exp(1, 31, "fill_31", 32'd32);
        rd_exp(0, 13, "fill_13", 32'd14);
        clr_req = 1;
        tick();
        clr_req = 0;
        n = 0;
        while (clr_busy && n < 40) begin
            if (n == 3) clr_req = 1;
            if (n == 10) begin
                wb_en = 1; wb_addr = 10; wb_data = 32'hCAFE;
                wa_en = 1; wa_addr = 20; wa_data = 32'h1234;
            end
            rd_check(0, n, "clr_ptr_rd");
            if (n % 8 == 0) rd_check(1, 31, "clr_tail_rd");
            chk("clr_busy", 32'(clr_busy), 32'(mbusy));
            chk("clr_nodone", 32'(clr_done), 32'h0);
            tick();
            clr_req = 0;
            idle_wr();
            n++;
        end
        chk("clr_len", 32'(n), 32'd32);
        chk("clr_done", 32'(clr_done), 32'h1);
        clr_req = 1;
        tick();
        clr_req = 0;
        chk("done_pulse", 32'(clr_done), 32'h0);
        chk("req_in_done_ignored", 32'(clr_busy), 32'h0);
        rd_exp(0, 10, "clr_vs_wr", 32'hCAFE);
        rd_exp(1, 20, "wr_ahead", 32'h0);
        for (int a = 0; a < 32; a++) rd_check(0, a, "post_clr");

        // Reset mid-clear
        fill();
        clr_req = 1;
        tick();
        clr_req = 0;
        for (int i = 0; i < 12; i++) tick();
        rd_exp(0, 12, "ptr12_byp", 32'h0);
        rd_exp(1, 13, "ptr12_ahead", 32'd14);
        #2 rst = 1;
        #1;
        chk("rst_mid_busy", 32'(clr_busy), 32'h0);
        chk("rst_mid_done", 32'(clr_done), 32'h0);
        model_reset();
        tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_mid_nodone", 32'(clr_done), 32'h0);
            tick();
        end
        for (int a = 0; a < 32; a++) rd_exp(0, a, "rst_mid_zero", 32'h0);
        clr_req = 1;
        tick();
        clr_req = 0;
        n = 0;
        while (clr_busy && n < 40) begin
            tick();
            n++;
        end
        chk("reclr_len", 32'(n), 32'd32);
        chk("reclr_done", 32'(clr_done), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
